// File: rtl/sram_controller_pkg.sv
// Shared definitions for the SRAM memory stage: FSM encoding, the default
// SRAM base address and the wait-counter width.
package sram_controller_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;
  localparam int unsigned CNT_W             = 4;

endpackage

// File: rtl/sram_controller_wait.sv
// Cycle counter for SRAM access phases: synchronous clear, count enable,
// and a terminal-count flag when the count equals TERMINAL.
module wait_counter
  import sram_controller_pkg::*;
#(
  parameter logic [CNT_W-1:0] TERMINAL = CNT_W'(2)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == TERMINAL);

endmodule

// File: rtl/sram_controller.sv
// Memory-stage controller that splits each 32-bit pipeline access into two
// 16-bit SRAM half-word accesses (low then high) and stalls via ready.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR     = BASE_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        is_write_q, is_write_d;

  logic        req;
  logic        in_access;
  logic        cnt_clr;
  logic        tc;
  logic [31:0] offset;
  logic [16:0] word_idx;
  logic        offset_unused;

  assign req       = rd_en | wr_en;
  assign in_access = (state_q == LOW) || (state_q == HIGH);
  // Counter sits at zero outside the access phases, so IDLE acceptance needs no explicit clear.
  assign cnt_clr   = !in_access || tc;

  wait_counter #(
    .TERMINAL(CNT_W'(ACCESS_CYCLES - 1))
  ) u_wait_counter (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (cnt_clr),
    .en_i  (in_access),
    .tc_o  (tc)
  );

  // Subtraction wraps modulo 2^32, so addresses below BASE_ADDR alias to the top of SRAM.
  assign offset        = addr_q - BASE_ADDR;
  assign word_idx      = offset[18:2];
  assign offset_unused = ^{offset[31:19], offset[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = LOW;
      LOW:     if (tc)  state_d = HIGH;
      HIGH:    if (tc)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (state_q)
      IDLE: ready = !req;
      LOW: begin
        sram_addr = {word_idx, 1'b0};
        if (is_write_q) begin
          sram_dq_out = wdata_q[15:0];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
      end
      HIGH: begin
        sram_addr = {word_idx, 1'b1};
        if (is_write_q) begin
          sram_dq_out = wdata_q[31:16];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
      end
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d     = address;
          wdata_d    = write_data;
          is_write_d = wr_en;
        end
      end
      LOW:     if (tc && !is_write_q) rdata_d[15:0]  = sram_dq_in;
      HIGH:    if (tc && !is_write_q) rdata_d[31:16] = sram_dq_in;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      is_write_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      is_write_q <= is_write_d;
    end
  end

  assign read_data = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: directed transactions push expected
// SRAM write beats and completions; negedge monitors pop and compare.
module tb_sram_controller;

  typedef struct {
    logic [31:0] rdata;
    int unsigned lat;
  } done_t;

  typedef struct {
    logic [17:0] addr;
    logic [15:0] dq;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance, ACCESS_CYCLES = 3
  logic        rd_en, wr_en, ready, sram_dq_oe, sram_we_n;
  logic [31:0] address, write_data, read_data;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;

  // Second instance, ACCESS_CYCLES = 1
  logic        rd_en1, wr_en1, ready1, sram_dq_oe1, sram_we_n1;
  logic [31:0] address1, write_data1, read_data1;
  logic [17:0] sram_addr1;
  logic [15:0] sram_dq_out1, sram_dq_in1;

  sram_controller #(.ACCESS_CYCLES(3), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  sram_controller #(.ACCESS_CYCLES(1), .BASE_ADDR(32'd1024)) dut1 (
    .clk(clk), .rst(rst), .rd_en(rd_en1), .wr_en(wr_en1),
    .address(address1), .write_data(write_data1), .read_data(read_data1),
    .ready(ready1), .sram_addr(sram_addr1), .sram_dq_out(sram_dq_out1),
    .sram_dq_in(sram_dq_in1), .sram_dq_oe(sram_dq_oe1), .sram_we_n(sram_we_n1)
  );

  // SRAM model for the main instance
  logic [15:0] mem [0:262143];
  always @(posedge clk) if (!sram_we_n) mem[sram_addr] <= sram_dq_out;
  assign sram_dq_in = mem[sram_addr];

  // Fixed pattern SRAM for the second instance: data = 0x1000 + half-word address
  assign sram_dq_in1 = 16'h1000 + sram_addr1[15:0];

  int unsigned checks = 0;
  int unsigned errors = 0;
  done_t done_q[$];
  done_t done1_q[$];
  beat_t beat_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Monitor for the main instance
  int unsigned lat = 0;
  always @(negedge clk) begin
    if (rst) begin
      lat = 0;
    end else begin
      if (!sram_we_n) begin
        if (beat_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual_addr=0x%05h actual_dq=0x%04h expected=no_write",
                   sram_addr, sram_dq_out);
        end else begin
          beat_t b;
          b = beat_q.pop_front();
          check("beat_addr", 32'(sram_addr), 32'(b.addr));
          check("beat_dq", 32'(sram_dq_out), 32'(b.dq));
          check("beat_oe", 32'(sram_dq_oe), 32'd1);
        end
      end else begin
        check("no_write_oe", 32'(sram_dq_oe), 32'd0);
      end
      if (ready) check("idle_sram_addr", 32'(sram_addr), 32'd0);
      if (rd_en || wr_en) begin
        if (ready) begin
          if (done_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=completion expected=none");
          end else begin
            done_t d;
            d = done_q.pop_front();
            check("read_data", read_data, d.rdata);
            check("latency", lat, d.lat);
          end
          lat = 0;
        end else begin
          lat++;
        end
      end
    end
  end

  // Monitor for the ACCESS_CYCLES=1 instance
  int unsigned lat1 = 0;
  always @(negedge clk) begin
    if (rst) begin
      lat1 = 0;
    end else if (rd_en1 || wr_en1) begin
      if (ready1) begin
        if (done1_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done1 actual=completion expected=none");
        end else begin
          done_t d;
          d = done1_q.pop_front();
          check("read_data1", read_data1, d.rdata);
          check("latency1", lat1, d.lat);
        end
        lat1 = 0;
      end else begin
        lat1++;
      end
    end
  end

  task automatic wait_ready();
    int unsigned n = 0;
    @(negedge clk);
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 expected=1");
    end
  endtask

  task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic [17:0] lo_a, input logic [17:0] hi_a);
    @(posedge clk); #1;
    done_q.push_back('{exp_rd, 7});
    if (wr) begin
      for (int i = 0; i < 3; i++) beat_q.push_back('{lo_a, wd[15:0]});
      for (int i = 0; i < 3; i++) beat_q.push_back('{hi_a, wd[31:16]});
    end
    rd_en = rd; wr_en = wr; address = addr; write_data = wd;
    wait_ready();
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    rd_en1 = 1'b0; wr_en1 = 1'b0; address1 = '0; write_data1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_read_data", read_data, 32'd0);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_sram_addr", 32'(sram_addr), 32'd0);
    check("rst_read_data1", read_data1, 32'd0);
    rst = 1'b0;

    //     rd    wr    address  write_data    exp read_data  lo beat    hi beat
    run_op(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'h00000000, 18'h00002, 18'h00003);
    run_op(1'b1, 1'b0, 32'd1028, 32'h00000000, 32'hDEADBEEF, 18'h00002, 18'h00003);
    run_op(1'b1, 1'b1, 32'd1032, 32'h12345678, 32'hDEADBEEF, 18'h00004, 18'h00005);
    run_op(1'b0, 1'b1, 32'd1020, 32'h0BADF00D, 32'hDEADBEEF, 18'h3FFFE, 18'h3FFFF);
    run_op(1'b1, 1'b0, 32'd1020, 32'h00000000, 32'h0BADF00D, 18'h3FFFE, 18'h3FFFF);

    // Back-to-back reads held high on the single-cycle instance
    begin
      int unsigned got = 0;
      int unsigned n = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) done1_q.push_back('{32'h10051004, 3});
      rd_en1 = 1'b1; address1 = 32'd1032;
      while (got < 3 && n < 40) begin
        @(negedge clk);
        n++;
        if (ready1) got++;
      end
      if (got < 3) begin
        checks++;
        errors++;
        $display("FAIL b2b_timeout actual=%0d expected=3", got);
      end
      @(posedge clk); #1;
      rd_en1 = 1'b0;
    end

    // Reset during the HIGH phase of a write
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) beat_q.push_back('{18'h00002, 16'hF00D});
    beat_q.push_back('{18'h00003, 16'hCAFE});
    wr_en = 1'b1; address = 32'd1028; write_data = 32'hCAFEF00D;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1; wr_en = 1'b0;
    #1;
    check("midrst_we_n", 32'(sram_we_n), 32'd1);
    check("midrst_oe", 32'(sram_dq_oe), 32'd0);
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_read_data", read_data, 32'd0);
    check("midrst_sram_addr", 32'(sram_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(ready), 32'd1);
    repeat (3) @(posedge clk);

    check("beats_left", 32'(beat_q.size()), 32'd0);
    check("done_left", 32'(done_q.size()), 32'd0);
    check("done1_left", 32'(done1_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
